crc_sequencer: RTL and testbench

- Sits between the control register and the CRC32 core. Buffers data words written over APB in a small FIFO.
- Sequences the core's reset/start/ready handshake one word at a time. Freezes the core's orientation while a run is in progress.
- Accumulates the final CRC result, a processed-word count, and a sticky timeout error, all readable by the control register.

---
 rtl/POLI_types_pkg.sv | 18 +
 rtl/crc_sequencer_sync_fifo.sv | 56 +++++
 rtl/crc_sequencer.sv | 142 ++++++++++++++
 tb/tb_crc_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/POLI_types_pkg.sv
// Shared types and constants for the POLI CRC path.
// Holds the sequencer state encoding and the default FIFO/timeout sizing.
package POLI_types_pkg;

    localparam int WORD_SIZE      = 32;
    localparam int CRC_FIFO_DEPTH = 8;
    localparam int CRC_TIMEOUT    = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } crc_seq_state_t;

endpackage

// File: rtl/crc_sequencer_sync_fifo.sv
// Single-clock FIFO with synchronous flush; depth must be a power of two.
// Pointers wrap naturally; occupancy is tracked in a separate counter.
module sync_fifo #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WORD_SIZE-1:0]     push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WORD_SIZE-1:0]     pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/crc_sequencer.sv
// Feeds buffered words to a CRC32 core one at a time via its reset/start/ready
// handshake, collecting the final CRC, a word count and a sticky timeout flag.
module crc_sequencer
    import POLI_types_pkg::*;
#(
    parameter int WORD_SIZE = POLI_types_pkg::WORD_SIZE,
    parameter int DEPTH     = POLI_types_pkg::CRC_FIFO_DEPTH,
    parameter int TIMEOUT   = POLI_types_pkg::CRC_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_valid,
    input  logic [WORD_SIZE-1:0]   wr_data,
    output logic                   wr_ready,
    input  logic                   cmd_clear,
    input  logic                   cmd_run,
    input  logic [WORD_SIZE-1:0]   orient_in,
    output logic [WORD_SIZE-1:0]   crc_data_in,
    output logic                   crc_reset,
    output logic                   crc_start,
    output logic [WORD_SIZE-1:0]   crc_orient,
    input  logic [WORD_SIZE-1:0]   crc_out,
    input  logic                   crc_ready,
    output logic [WORD_SIZE-1:0]   result,
    output logic                   result_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            words_done,
    output logic                   timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    crc_seq_state_t       state;
    crc_seq_state_t       next_state;
    logic [WORD_SIZE-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic [TW-1:0]        wait_cnt;

    assign fifo_pop   = (state == ISSUE);
    assign fifo_flush = (state == CLR) || (state == ERR);
    assign wr_ready   = !fifo_full;
    assign busy       = (state != IDLE);

    sync_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        crc_start  = 1'b0;
        crc_reset  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_run) next_state = fifo_empty ? DONE : ISSUE;
            end
            CLR: begin
                crc_reset  = 1'b1;
                next_state = IDLE;
            end
            ISSUE: begin
                crc_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (crc_ready)               next_state = fifo_empty ? DONE : ISSUE;
                else if (wait_cnt == TO_LAST) next_state = ERR;
            end
            DONE:    next_state = IDLE;
            ERR: begin
                crc_reset  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // An abort wins over everything else, including a same-cycle crc_ready.
        if (cmd_clear) next_state = CLR;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_orient   <= '0;
            crc_data_in  <= '0;
            wait_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            words_done   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (state == IDLE) crc_orient <= orient_in;
            // Load on entry to ISSUE so the word lines up with the start pulse.
            if (next_state == ISSUE) crc_data_in <= fifo_head;
            case (state)
                IDLE: begin
                    if (cmd_run && !cmd_clear) result_valid <= 1'b0;
                end
                CLR: begin
                    result       <= '0;
                    words_done   <= '0;
                    timeout_err  <= 1'b0;
                    result_valid <= 1'b0;
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (crc_ready) begin
                        if (!cmd_clear) begin
                            result <= crc_out;
                            if (words_done != 16'hFFFF) words_done <= words_done + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                DONE:    result_valid <= 1'b1;
                ERR:     timeout_err  <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_sequencer.sv
// Directed bench for crc_sequencer with a scoreboard on the core-facing data
// and a simple CRC core model that answers one cycle after each start.
module tb_crc_sequencer;
    import POLI_types_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          cmd_clear;
    logic          cmd_run;
    logic [W-1:0]  orient_in;
    logic [W-1:0]  crc_data_in;
    logic          crc_reset;
    logic          crc_start;
    logic [W-1:0]  crc_orient;
    logic [W-1:0]  crc_out;
    logic          crc_ready;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          busy;
    logic [3:0]    fifo_count;
    logic [15:0]   words_done;
    logic          timeout_err;

    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_exp;
    int            mcount = 0;
    int            core_mode = 0;
    int            cyc = 0;
    int            start_total = 0;
    int            reset_pulses = 0;
    int            prev_start_cyc = 0;
    int            last_start_cyc = 0;
    int            last_reset_cyc = 0;
    logic [W-1:0]  core_cnt;

    crc_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .cmd_clear    (cmd_clear),
        .cmd_run      (cmd_run),
        .orient_in    (orient_in),
        .crc_data_in  (crc_data_in),
        .crc_reset    (crc_reset),
        .crc_start    (crc_start),
        .crc_orient   (crc_orient),
        .crc_out      (crc_out),
        .crc_ready    (crc_ready),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .words_done   (words_done),
        .timeout_err  (timeout_err)
    );

    // Clock and reset-independent cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Core model: mode 0 answers 0xAAAA0000+n one cycle after the n-th start
    // since its last reset; mode 1 never answers.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_ready <= 1'b0;
            crc_out   <= '0;
            core_cnt  <= '0;
        end else begin
            crc_ready <= 1'b0;
            if (crc_reset) begin
                core_cnt <= '0;
            end else if (crc_start && core_mode == 0) begin
                crc_ready <= 1'b1;
                crc_out   <= 32'hAAAA0000 + core_cnt + 32'd1;
                core_cnt  <= core_cnt + 32'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every start pulse must carry the next word from the scoreboard
    always @(negedge CLK) begin
        if (!RST) begin
            if (crc_start || crc_reset)
                check("start_reset_exclusive", 32'(crc_start & crc_reset), 32'd0);
            if (crc_start) begin
                start_total++;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("start_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("crc_data_in", crc_data_in, mon_exp);
                end
            end
            if (crc_reset) begin
                reset_pulses++;
                last_reset_cyc = cyc;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        check("wr_ready", 32'(wr_ready), 32'(mcount < DEPTH));
        wr_valid = 1'b1;
        wr_data  = w;
        if (mcount < DEPTH) begin
            exp_q.push_back(w);
            mcount++;
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        exp_q.delete();
        mcount = 0;
    endtask

    task automatic pulse_run();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        mcount = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge CLK);
        while (busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int n;
        wr_valid  = 1'b0;
        wr_data   = '0;
        cmd_clear = 1'b0;
        cmd_run   = 1'b0;
        orient_in = '0;

        // Reset state
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_wr_ready",     32'(wr_ready),     32'd1);
        check("rst_fifo_count",   32'(fifo_count),   32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_result",       result,            32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_words_done",   32'(words_done),   32'd0);
        check("rst_timeout_err",  32'(timeout_err),  32'd0);
        check("rst_crc_start",    32'(crc_start),    32'd0);
        check("rst_crc_reset",    32'(crc_reset),    32'd0);
        check("rst_crc_orient",   crc_orient,        32'd0);
        check("rst_crc_data_in",  crc_data_in,       32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("idle_busy",       32'(busy),       32'd0);
        check("idle_wr_ready",   32'(wr_ready),   32'd1);

        // Two words, instant core
        pulse_clear();
        tick();
        push_word(32'h31323334);
        push_word(32'h35363738);
        @(negedge CLK);
        check("two_fifo_count", 32'(fifo_count), 32'd2);
        pulse_run();
        wait_idle(50);
        check("two_result",       result,                               32'hAAAA0002);
        check("two_words_done",   32'(words_done),                      32'd2);
        check("two_result_valid", 32'(result_valid),                    32'd1);
        check("two_start_gap",    32'(last_start_cyc - prev_start_cyc), 32'd2);
        check("two_sb_drained",   32'(exp_q.size()),                    32'd0);

        // Nine pushes into an eight-deep FIFO
        pulse_clear();
        tick();
        for (int i = 0; i < 9; i++) push_word(32'h10000000 + 32'(i));
        @(negedge CLK);
        check("full_fifo_count", 32'(fifo_count), 32'd8);
        check("full_wr_ready",   32'(wr_ready),   32'd0);
        s0 = start_total;
        pulse_run();
        wait_idle(100);
        check("full_words_done", 32'(words_done),         32'd8);
        check("full_result",     result,                  32'hAAAA0008);
        check("full_starts",     32'(start_total - s0),   32'd8);
        check("full_sb_drained", 32'(exp_q.size()),       32'd0);
        check("full_fifo_empty", 32'(fifo_count),         32'd0);

        // Run on an empty FIFO
        pulse_run();
        @(negedge CLK);
        check("empty_busy",         32'(busy),         32'd1);
        check("empty_valid_clear",  32'(result_valid), 32'd0);
        wait_idle(10);
        check("empty_result_valid", 32'(result_valid), 32'd1);
        check("empty_result_kept",  result,            32'hAAAA0008);
        check("empty_words_kept",   32'(words_done),   32'd8);

        // Core never answers: timeout
        core_mode = 1;
        push_word(32'hDEAD0001);
        push_word(32'hDEAD0002);
        r0 = reset_pulses;
        pulse_run();
        n = 0;
        while (reset_pulses == r0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("to_reached",      32'(reset_pulses != r0),              32'd1);
        check("to_wait_cycles",  32'(last_reset_cyc - last_start_cyc), 32'd65);
        @(negedge CLK);
        check("to_timeout_err",  32'(timeout_err),         32'd1);
        check("to_fifo_flushed", 32'(fifo_count),          32'd0);
        check("to_result_valid", 32'(result_valid),        32'd0);
        check("to_busy",         32'(busy),                32'd0);
        check("to_reset_pulses", 32'(reset_pulses - r0),   32'd1);
        exp_q.delete();
        core_mode = 0;
        pulse_clear();
        tick();
        @(negedge CLK);
        check("to_cleared", 32'(timeout_err), 32'd0);

        // Orientation frozen during a run
        push_word(32'h0000AAA1);
        push_word(32'h0000AAA2);
        push_word(32'h0000AAA3);
        pulse_run();
        tick();
        orient_in = 32'h5;
        n = 0;
        @(negedge CLK);
        while (busy && n < 50) begin
            check("orient_frozen", crc_orient, 32'h0);
            @(negedge CLK);
            n++;
        end
        check("orient_run_end", 32'(busy), 32'd0);
        @(negedge CLK);
        check("orient_follow",    crc_orient,       32'h5);
        check("orient_words",     32'(words_done),  32'd3);
        check("orient_result",    result,           32'hAAAA0003);

        // Clear and run together while waiting with three words queued
        core_mode = 1;
        for (int i = 0; i < 4; i++) push_word(32'hC0DE0000 + 32'(i));
        pulse_run();
        tick();
        @(negedge CLK);
        check("abort_fifo_count", 32'(fifo_count), 32'd3);
        check("abort_words_pre",  32'(words_done), 32'd3);
        check("abort_busy_pre",   32'(busy),       32'd1);
        s0 = start_total;
        r0 = reset_pulses;
        cmd_clear = 1'b1;
        cmd_run   = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_run   = 1'b0;
        exp_q.delete();
        mcount = 0;
        @(negedge CLK);
        check("abort_crc_reset", 32'(crc_reset), 32'd1);
        check("abort_crc_start", 32'(crc_start), 32'd0);
        tick();
        @(negedge CLK);
        check("abort_fifo_flushed", 32'(fifo_count), 32'd0);
        check("abort_words_clear",  32'(words_done), 32'd0);
        check("abort_result_clear", result,          32'd0);
        check("abort_busy",         32'(busy),       32'd0);
        repeat (10) @(negedge CLK);
        check("abort_no_start",     32'(start_total - s0),  32'd0);
        check("abort_one_reset",    32'(reset_pulses - r0), 32'd1);
        core_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
